scan_sequencer: RTL
===================

# scan_sequencer

Generates the 3-bit select address that drives the 3-to-8 one-hot decoder stage, stepping through eight output positions (display digits / LED columns) at a programmable rate. Supports run/stop control, single-step, up/down direction and a per-position enable mask so disabled positions are skipped. It sits directly upstream of the decoder: its `sel` output connects straight to the decoder's 3-bit input.

## Interface
- `PRESCALE`, 50000: clock cycles per advance while running; legal range 1..2^24-1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  level/pulse; IDLE→RUN.
- `stop`  in  1  level/pulse; RUN→IDLE.
- `step`  in  1  advance one position; honoured only in IDLE.
- `dir`  in  1  1 = ascending, 0 = descending; sampled every advance (fixed direction mode).
- `pingpong`  in  1  bounce mode request; ignored unless `SCAN_PINGPONG_EN` is defined.
- `en_mask`  in  8  bit i = 1 enables position i.
- `sel`  out  3  current position; feeds decoder.
- `sel_valid`  out  1  combinational `en_mask[sel]`.
- `wrap`  out  1  one-cycle pulse on the cycle `sel` wraps (or reverses).
- `busy`  out  1  high in RUN.

## Operation
- Two states: IDLE, RUN. Reset values: state IDLE, `sel`=0, `wrap`=0, `busy`=0, prescaler count 0, internal bounce direction = ascending.
- IDLE: `start`=1 → RUN, prescaler cleared to 0. `step`=1 (and `start`=0) → one advance next edge, stay IDLE.
- RUN: prescaler counts 0..PRESCALE-1; on count==PRESCALE-1 it returns to 0 and an advance occurs. `stop`=1 → IDLE; no advance in that cycle even if tick coincides.
- Priority same cycle: `stop` > `start` > `step`. `start` in RUN and `step` in RUN are ignored.
- Advance (fixed mode): new `sel` = nearest enabled index strictly beyond current in direction `dir`, modulo 8. If the only enabled index is current, `sel` unchanged. `wrap`=1 when ascending and new `sel` <= old, or descending and new `sel` >= old.
- `en_mask`=0: advances leave `sel` unchanged, `wrap` stays 0; state machine still runs.
- Mask changing while disabled position is selected: next advance searches from current `sel` as usual; `sel_valid` low until then.
- Arithmetic: index arithmetic is 3-bit modulo 8; prescaler width = $clog2(PRESCALE) min 1.

## Timing
- `sel`, `wrap`, `busy` registered; `sel_valid` combinational from `sel` and `en_mask`.
- `start` seen at edge N: `busy`=1 after N; first advance after edge N+PRESCALE.
- Successive advances exactly PRESCALE cycles apart while RUN. PRESCALE=1 advances every cycle.
- `step` at edge N: `sel` updated after edge N.
- `rst_n`=0 mid-RUN: all registers to reset values at that edge, regardless of other inputs.

## Configuration
- `SCAN_PINGPONG_EN` defined: when `pingpong`=1, direction is the internal bounce direction, not `dir`. Advance past highest enabled index (ascending) or lowest (descending) instead reverses: internal direction flips and `sel` moves to nearest enabled index in the new direction; `wrap` pulses on each reversal. Single enabled index: `sel` held, `wrap` pulses each advance. Bounce direction reset to ascending on entry to RUN.
- Not defined: `pingpong` unused, no bounce logic synthesised; fixed mode only.

## Structure
- `scan_pkg`: state enum (IDLE, RUN), `SEL_W`=3, `NPOS`=8 constants, next-enabled-index search function.
- Sub-module `scan_prescaler`: counter with clear/enable, emits one-cycle `tick`.

## Test plan
- Reset, PRESCALE=4, mask 8'hFF, dir=1, start pulse → `sel` 0,1,2… every 4 cycles; `wrap` pulses once on 7→0; `busy`=1.
- Mask 8'b1010_0100, dir=1, RUN → `sel` sequence 2,5,7,2 with `wrap` on 7→2; dir=0 gives 7,5,2,7 with `wrap` on 2→7.
- IDLE, `step` x3, mask 8'hFF, dir=0 from `sel`=0 → 7 (wrap), 6, 5; prescaler unaffected.
- `start` and `stop` asserted same cycle in IDLE → stays IDLE; `stop` on tick cycle in RUN → no advance, `busy`=0 next cycle.
- Mask 0 in RUN → `sel` constant, `wrap`=0, `sel_valid`=0; `rst_n` low mid-RUN → `sel`=0, `busy`=0 after edge.
- With `SCAN_PINGPONG_EN`, pingpong=1, mask 8'h0F → `sel` 0,1,2,3,2,1,0,1; `wrap` at 3→2 and 0→1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and the enabled-position search used by scan_sequencer.
// Positions are 3-bit indices into an 8-entry enable mask.
package scan_pkg;

  localparam int SEL_W = 3;
  localparam int NPOS  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } search_t;

  // Nearest enabled index strictly beyond cur in the given direction.
  // circ=1 wraps modulo NPOS (and finally lands back on cur itself);
  // circ=0 stops at the ends of the position range.
  function automatic search_t scan_search(input logic [SEL_W-1:0] cur,
                                          input logic [NPOS-1:0]  mask,
                                          input logic             asc,
                                          input logic             circ);
    search_t r;
    int      t;
    r.found = 1'b0;
    r.idx   = cur;
    for (int k = 1; k <= NPOS; k++) begin
      t = asc ? (int'(cur) + k) : (int'(cur) - k);
      if (!r.found && (circ || (t >= 0 && t < NPOS))) begin
        if (mask[t[SEL_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = t[SEL_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider for scan_sequencer: counts 0..PRESCALE-1 while enabled
// and flags the terminal count with a one-cycle tick.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Select-address sequencer for a 3-to-8 decoder with run/stop, single-step,
// direction and skip mask. Define SCAN_PINGPONG_EN to add bounce mode.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             dir,
  input  logic             pingpong,
  input  logic [NPOS-1:0]  en_mask,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             wrap,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             presc_clr;
  logic             advance;
  logic             adv_asc;
  logic [SEL_W-1:0] adv_sel;
  logic             adv_wrap;
  search_t          circ_s;

  assign presc_clr = (state_q == ST_IDLE) && start && !stop;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (state_q == ST_RUN),
    .tick  (tick)
  );

`ifdef SCAN_PINGPONG_EN
  logic    bdir_q, bdir_d;
  logic    adv_bdir;
  search_t line_fwd_s, line_rev_s;

  assign adv_asc    = pingpong ? bdir_q : dir;
  assign line_fwd_s = scan_search(sel_q, en_mask, bdir_q, 1'b0);
  assign line_rev_s = scan_search(sel_q, en_mask, !bdir_q, 1'b0);
`else
  logic unused_pingpong;
  assign unused_pingpong = pingpong;
  assign adv_asc         = dir;
`endif

  assign circ_s = scan_search(sel_q, en_mask, adv_asc, 1'b1);

  always_comb begin
    adv_sel  = circ_s.found ? circ_s.idx : sel_q;
    adv_wrap = circ_s.found &&
               (adv_asc ? (circ_s.idx <= sel_q) : (circ_s.idx >= sel_q));
`ifdef SCAN_PINGPONG_EN
    adv_bdir = bdir_q;
    if (pingpong) begin
      adv_sel  = sel_q;
      adv_wrap = 1'b0;
      if (line_fwd_s.found) begin
        adv_sel = line_fwd_s.idx;
      end else if (en_mask != '0) begin
        // Ran off the end: reverse, and hold if nothing lies the other way.
        adv_bdir = !bdir_q;
        adv_wrap = 1'b1;
        if (line_rev_s.found) begin
          adv_sel = line_rev_s.idx;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    advance = 1'b0;
    if (state_q == ST_IDLE) begin
      if (stop) begin
        state_d = ST_IDLE;
      end else if (start) begin
        state_d = ST_RUN;
        busy_d  = 1'b1;
      end else if (step) begin
        advance = 1'b1;
      end
    end else begin
      if (stop) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else if (tick) begin
        advance = 1'b1;
      end
    end

    sel_d  = advance ? adv_sel : sel_q;
    wrap_d = advance && adv_wrap;
`ifdef SCAN_PINGPONG_EN
    if (presc_clr) begin
      bdir_d = 1'b1;
    end else if (advance) begin
      bdir_d = adv_bdir;
    end else begin
      bdir_d = bdir_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SCAN_PINGPONG_EN
      bdir_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
`ifdef SCAN_PINGPONG_EN
      bdir_q  <= bdir_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
  assign sel_valid = en_mask[sel_q];

endmodule
